// File: rtl/disp_pkg.sv
// Shared encodings for the display message scheduler: message codes, FSM states
// and the priority helper used when requests compete.
package disp_pkg;

    localparam logic [1:0] MSG_NUM = 2'b00;
    localparam logic [1:0] MSG_OP  = 2'b01;
    localparam logic [1:0] MSG_VAL = 2'b10;
    localparam logic [1:0] MSG_ERR = 2'b11;

    typedef enum logic {
        NUM  = 1'b0,
        HOLD = 1'b1
    } state_e;

    // The code values happen to be priority-ordered; keep the mapping explicit
    // so a future re-encoding does not silently change arbitration.
    function automatic logic [1:0] msg_prio(input logic [1:0] code);
        logic [1:0] p;
        case (code)
            MSG_ERR: p = 2'd3;
            MSG_VAL: p = 2'd2;
            MSG_OP:  p = 2'd1;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/disp_hold_timer.sv
// Message hold timer: down-counter loaded on restart, registered expire pulse
// marks the last held cycle. en means "holding in the coming cycle".
module disp_hold_timer #(
    parameter  int HOLD_CYCLES = 100_000_000,
    localparam int TMR_W       = $clog2(HOLD_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic en,
    output logic expire
);

    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             expire_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (restart) begin
            cnt_d = TMR_W'(HOLD_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= en && (cnt_d == '0);
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/disp_msg_scheduler.sv
// Display message scheduler: shares the 7-segment decoder between the current
// number and timed ERR/VAL/OP messages. Optional pending slot: DISP_PEND_QUEUE_EN.
//
// state | meaning
// NUM   | decoder shows the registered number
// HOLD  | a timed status message is on the display
module disp_msg_scheduler
    import disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       num_valid,
    input  logic [7:0] num_bin,
    input  logic       num_sgn,
    input  logic [1:0] num_dot,
    input  logic       err_req,
    input  logic       val_req,
    input  logic       op_req,
    output logic [1:0] msg,
    output logic [7:0] bin,
    output logic       sgn,
    output logic [1:0] dot,
    output logic       busy,
    output logic       msg_done
);

    state_e     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic [1:0] req_code;
    logic       restart;
    logic       expire;
    logic [7:0] bin_q;
    logic       sgn_q;
    logic [1:0] dot_q;

`ifdef DISP_PEND_QUEUE_EN
    // MSG_NUM doubles as "pending slot empty"; it has the lowest priority.
    logic [1:0] pend_q, pend_d;
    logic [1:0] best_code;
    assign best_code = (msg_prio(req_code) > msg_prio(pend_q)) ? req_code : pend_q;
`endif

    assign req_code = err_req ? MSG_ERR :
                      val_req ? MSG_VAL :
                      op_req  ? MSG_OP  : MSG_NUM;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= NUM;
            code_q  <= MSG_NUM;
`ifdef DISP_PEND_QUEUE_EN
            pend_q  <= MSG_NUM;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
`ifdef DISP_PEND_QUEUE_EN
            pend_q  <= pend_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        restart = 1'b0;
`ifdef DISP_PEND_QUEUE_EN
        pend_d  = pend_q;
`endif
        if (clr) begin
            state_d = NUM;
            code_d  = MSG_NUM;
`ifdef DISP_PEND_QUEUE_EN
            pend_d  = MSG_NUM;
`endif
        end else begin
            case (state_q)
                NUM: begin
                    if (req_code != MSG_NUM) begin
                        state_d = HOLD;
                        code_d  = req_code;
                        restart = 1'b1;
                    end
                end
                HOLD: begin
                    // Preempt or retrigger wins even in the expiry cycle.
                    if (req_code != MSG_NUM && msg_prio(req_code) >= msg_prio(code_q)) begin
                        code_d  = req_code;
                        restart = 1'b1;
                    end else if (expire) begin
`ifdef DISP_PEND_QUEUE_EN
                        if (best_code != MSG_NUM) begin
                            code_d  = best_code;
                            restart = 1'b1;
                            pend_d  = MSG_NUM;
                        end else begin
                            state_d = NUM;
                            code_d  = MSG_NUM;
                        end
`else
                        state_d = NUM;
                        code_d  = MSG_NUM;
`endif
                    end
`ifdef DISP_PEND_QUEUE_EN
                    else if (msg_prio(req_code) > msg_prio(pend_q)) begin
                        pend_d = req_code;
                    end
`endif
                end
                default: begin
                    state_d = NUM;
                    code_d  = MSG_NUM;
                end
            endcase
        end
    end

    always_comb begin
        msg  = (state_q == HOLD) ? code_q : MSG_NUM;
        busy = (state_q == HOLD);
    end

    disp_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .en      (state_d == HOLD),
        .expire  (expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q <= '0;
            sgn_q <= 1'b0;
            dot_q <= '0;
        end else if (clr) begin
            bin_q <= '0;
            sgn_q <= 1'b0;
            dot_q <= '0;
        end else if (num_valid) begin
            bin_q <= num_bin;
            sgn_q <= num_sgn;
            dot_q <= num_dot;
        end
    end

    assign bin      = bin_q;
    assign sgn      = sgn_q;
    assign dot      = dot_q;
    assign msg_done = expire;

endmodule

// File: tb/tb_disp_msg_scheduler.sv
// Scoreboard bench for disp_msg_scheduler with HOLD_CYCLES=8; expectations
// follow DISP_PEND_QUEUE_EN when the macro is defined.
module tb_disp_msg_scheduler;
    import disp_pkg::*;

    typedef struct packed {
        logic [1:0] msg;
        logic [7:0] bin;
        logic       sgn;
        logic [1:0] dot;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       num_valid;
    logic [7:0] num_bin;
    logic       num_sgn;
    logic [1:0] num_dot;
    logic       err_req;
    logic       val_req;
    logic       op_req;
    logic [1:0] msg;
    logic [7:0] bin;
    logic       sgn;
    logic [1:0] dot;
    logic       busy;
    logic       msg_done;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   vec    = 0;
    logic [7:0] cur_bin = 8'd0;
    logic       cur_sgn = 1'b0;
    logic [1:0] cur_dot = 2'd0;

    always #5 clk = ~clk;

    disp_msg_scheduler #(.HOLD_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .num_valid (num_valid),
        .num_bin   (num_bin),
        .num_sgn   (num_sgn),
        .num_dot   (num_dot),
        .err_req   (err_req),
        .val_req   (val_req),
        .op_req    (op_req),
        .msg       (msg),
        .bin       (bin),
        .sgn       (sgn),
        .dot       (dot),
        .busy      (busy),
        .msg_done  (msg_done)
    );

    function automatic exp_t mk(input logic [1:0] m, input logic d);
        exp_t e;
        e.msg  = m;
        e.bin  = cur_bin;
        e.sgn  = cur_sgn;
        e.dot  = cur_dot;
        e.busy = (m != MSG_NUM);
        e.done = d;
        return e;
    endfunction

    // One clock: inputs set beforehand are sampled at this edge, then the
    // expected post-edge outputs are queued and single-cycle inputs drop.
    task automatic tick(input logic [1:0] m, input logic d);
        @(posedge clk);
        #1;
        sb.push_back(mk(m, d));
        err_req   = 1'b0;
        val_req   = 1'b0;
        op_req    = 1'b0;
        num_valid = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic hold(input logic [1:0] m, input int n);
        for (int i = 0; i < n; i++) tick(m, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t act;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                act = {msg, bin, sgn, dot, busy, msg_done};
                checks++;
                if (act === e) begin
                    passed++;
                end else begin
                    $display("FAIL vec%0d: got msg=%b bin=%0d sgn=%b dot=%0d busy=%b done=%b, want msg=%b bin=%0d sgn=%b dot=%0d busy=%b done=%b",
                             vec, act.msg, act.bin, act.sgn, act.dot, act.busy, act.done,
                             e.msg, e.bin, e.sgn, e.dot, e.busy, e.done);
                end
                vec++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        rst = 1'b0; clr = 1'b0; num_valid = 1'b0; num_bin = 8'd0; num_sgn = 1'b0;
        num_dot = 2'd0; err_req = 1'b0; val_req = 1'b0; op_req = 1'b0;

        // Reset values.
        tick(MSG_NUM, 1'b0);
        tick(MSG_NUM, 1'b0);
        rst = 1'b1;

        // Number load.
        num_valid = 1'b1; num_bin = 8'd123; num_sgn = 1'b1; num_dot = 2'd2;
        cur_bin = 8'd123; cur_sgn = 1'b1; cur_dot = 2'd2;
        tick(MSG_NUM, 1'b0);

        // OP pulse: 8 cycles, done on the 8th, number on the 9th.
        op_req = 1'b1;
        tick(MSG_OP, 1'b0);
        hold(MSG_OP, 6);
        tick(MSG_OP, 1'b1);
        tick(MSG_NUM, 1'b0);

        // VAL preempted by ERR three cycles later; only ERR completes.
        val_req = 1'b1;
        tick(MSG_VAL, 1'b0);
        hold(MSG_VAL, 2);
        err_req = 1'b1;
        tick(MSG_ERR, 1'b0);
        hold(MSG_ERR, 6);
        tick(MSG_ERR, 1'b1);
        tick(MSG_NUM, 1'b0);

        // Simultaneous ERR and OP: OP is the same-cycle loser.
        err_req = 1'b1; op_req = 1'b1;
        tick(MSG_ERR, 1'b0);
        hold(MSG_ERR, 6);
        tick(MSG_ERR, 1'b1);
        tick(MSG_NUM, 1'b0);
        tick(MSG_NUM, 1'b0);

        // Lower-priority VAL during ERR hold.
        err_req = 1'b1;
        tick(MSG_ERR, 1'b0);
        tick(MSG_ERR, 1'b0);
        val_req = 1'b1;
        tick(MSG_ERR, 1'b0);
        hold(MSG_ERR, 4);
        tick(MSG_ERR, 1'b1);
`ifdef DISP_PEND_QUEUE_EN
        tick(MSG_VAL, 1'b0);
        hold(MSG_VAL, 6);
        tick(MSG_VAL, 1'b1);
`endif
        tick(MSG_NUM, 1'b0);

        // Equal-priority retrigger mid-hold with a value load, then retrigger
        // in the msg_done cycle.
        op_req = 1'b1;
        tick(MSG_OP, 1'b0);
        hold(MSG_OP, 3);
        op_req = 1'b1; num_valid = 1'b1; num_bin = 8'd45; num_sgn = 1'b0; num_dot = 2'd1;
        cur_bin = 8'd45; cur_sgn = 1'b0; cur_dot = 2'd1;
        tick(MSG_OP, 1'b0);
        hold(MSG_OP, 6);
        tick(MSG_OP, 1'b1);
        op_req = 1'b1;
        tick(MSG_OP, 1'b0);
        hold(MSG_OP, 6);
        tick(MSG_OP, 1'b1);
        tick(MSG_NUM, 1'b0);

        // clr in hold cycle 4 overrides a simultaneous load.
        err_req = 1'b1;
        tick(MSG_ERR, 1'b0);
        hold(MSG_ERR, 3);
        clr = 1'b1; num_valid = 1'b1; num_bin = 8'd77; num_sgn = 1'b1; num_dot = 2'd1;
        cur_bin = 8'd0; cur_sgn = 1'b0; cur_dot = 2'd0;
        tick(MSG_NUM, 1'b0);
        tick(MSG_NUM, 1'b0);
        tick(MSG_NUM, 1'b0);

        // Asynchronous reset in the middle of a VAL hold.
        num_valid = 1'b1; num_bin = 8'd9; num_sgn = 1'b0; num_dot = 2'd3;
        cur_bin = 8'd9; cur_sgn = 1'b0; cur_dot = 2'd3;
        tick(MSG_NUM, 1'b0);
        val_req = 1'b1;
        tick(MSG_VAL, 1'b0);
        tick(MSG_VAL, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur_bin = 8'd0; cur_sgn = 1'b0; cur_dot = 2'd0;
        #1;
        sb.push_back(mk(MSG_NUM, 1'b0));
        tick(MSG_NUM, 1'b0);
        rst = 1'b1;
        hold(MSG_NUM, 8);

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/disp_msg_scheduler.md
Name: disp_msg_scheduler

Overview:
- Sequencer/arbiter in front of the 4-digit 7-segment decoder (msg/bin/sgn/dot inputs).
- Holds the current calculator number and shares the display between it and three timed status messages: ERR, VAL, OP.
- Fixed priority between the messages; each timed message is held for HOLD_CYCLES, then the display reverts to the number.
- Outputs connect directly to the decoder.

Parameters:
- HOLD_CYCLES, 100_000_000, cycles a status message stays on the display; must be >= 2.
- TMR_W, $clog2(HOLD_CYCLES), hold counter width; derived, never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear: value 0, number mode, abort any message.
- num_valid  in  1  load num_bin/num_sgn/num_dot into the value register this cycle.
- num_bin  in  8  unsigned magnitude 0..255.
- num_sgn  in  1  1 = negative (decoder shows "-").
- num_dot  in  2  decimal point digit; 1 or 2 lights a dot, 0/3 = none.
- err_req  in  1  request ERR message (pulse or level, sampled every cycle).
- val_req  in  1  request VAL message.
- op_req  in  1  request OP message.
- msg  out  2  00 number, 01 OP, 10 VAL, 11 ERR.
- bin  out  8  registered value magnitude.
- sgn  out  1  registered value sign.
- dot  out  2  registered dot position.
- busy  out  1  1 while a timed message is displayed.
- msg_done  out  1  one-cycle pulse in the last held cycle of a message.

Behaviour:
- Reset (rst=0, async): msg=00, bin=0, sgn=0, dot=0, busy=0, msg_done=0, state NUM, timer=0, pending empty.
- All outputs are registered. A request sampled at edge k appears on msg after edge k, so latency is 1 cycle.
- Value register:
  - num_valid loads {bin,sgn,dot} in any state; the value is visible 1 cycle later.
  - Loading during a message changes bin but not msg.
  - bin/sgn/dot are always driven; the decoder ignores them when msg != 00.
- Priority: ERR > VAL > OP. Simultaneous requests select the highest; the rest are dropped (see Optional Feature).
- State NUM: msg=00, busy=0. Any request moves to HOLD with msg=code, timer=0, busy=1.
- State HOLD:
  - Timer increments each cycle.
  - At timer==HOLD_CYCLES-1: msg_done=1; next cycle returns to NUM (msg=00, busy=0).
  - The message is therefore visible for exactly HOLD_CYCLES cycles.
- Requests while in HOLD:
  - Strictly higher priority: preempts, msg switches next cycle, timer restarts at 0, no msg_done for the aborted message.
  - Equal priority: retriggers, timer restarts at 0.
  - Lower priority: dropped.
  - A request in the msg_done cycle is treated as a HOLD request by the same rules; a retrigger cancels the return to NUM.
- clr (synchronous):
  - Overrides all requests and num_valid in the same cycle.
  - Next cycle: msg=00, bin=0, sgn=0, dot=0, busy=0, msg_done=0, timer=0, pending cleared.
- Reset asserted mid-hold: immediate return to reset values; no msg_done.

Optional Feature:
- Macro: DISP_PEND_QUEUE_EN.
- Defined:
  - One-entry pending register. A lower-priority request during HOLD is stored; a later one replaces the stored entry only if it has higher priority.
  - A preempted message is not requeued.
  - At hold expiry (msg_done cycle), if pending is valid, the next cycle shows the pending code with timer=0 and busy=1 (no NUM cycle), then clears pending.
  - A request in the expiry cycle competes with pending by priority; the loser is dropped.
- Undefined: lower-priority requests in HOLD are dropped; no pending storage is synthesised.

Decomposition:
- Package disp_pkg:
  - msg encoding constants MSG_NUM=2'b00, MSG_OP=2'b01, MSG_VAL=2'b10, MSG_ERR=2'b11.
  - State enum {NUM, HOLD}.
  - Function msg_prio(code) returning 0..3 for comparisons.
- Sub-module disp_hold_timer: inputs restart and en; outputs expire. Parameterised by HOLD_CYCLES. Reused by the future blink/timeout logic.

Test Plan (HOLD_CYCLES=8):
- Reset then num_valid with bin=123, sgn=1, dot=2 -> next cycle bin=123, sgn=1, dot=2, msg=00, busy=0.
- op_req pulse -> msg=01 for exactly 8 cycles; msg_done high in the 8th cycle; msg=00 in the 9th.
- val_req, then err_req 3 cycles later -> msg 10 then 11; ERR lasts 8 cycles from preemption; single msg_done.
- err_req and op_req in the same cycle -> msg=11 only; OP never shown without the macro. With DISP_PEND_QUEUE_EN, OP is still dropped (same-cycle loser).
- During ERR hold, val_req -> without the macro: back to msg=00 after ERR. With DISP_PEND_QUEUE_EN: msg=10 immediately after ERR expires, for 8 cycles.
- clr at hold cycle 4 with num_valid=1 -> next cycle msg=00, bin=0, busy=0, no msg_done. rst low mid-hold -> outputs zero asynchronously.
